// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the up/down snapshot counter.
// Digit stepping lives in bcd_digit_updown; this package holds the pure helpers.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Widest counter the leading-zero helper can scan.
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_COUNT = 2'd3
    } count_action_e;

    function automatic bcd_digit_t bcd_sat(input bcd_digit_t value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

    // Zero digits from the MSD downward; digit 0 is never counted, so the
    // result is capped at digits-1 and at least one digit stays visible.
    function automatic int leading_zeros(input logic [4*MAX_DIGITS-1:0] value,
                                         input int digits);
        int  count;
        logic running;
        count   = 0;
        running = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                if (running && (value[4*i +: 4] == 4'd0)) begin
                    count = count + 1;
                end else begin
                    running = 1'b0;
                end
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of the ripple chain: steps up or down when carry_in is set
// and raises carry_out when the digit rolls over (9->0 up, 0->9 down).
module bcd_digit_updown
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       up,
    input  logic       carry_in,
    output bcd_digit_t digit_next,
    output logic       carry_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    digit_next = 4'd0;
                    carry_out  = 1'b1;
                end else begin
                    digit_next = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    digit_next = BCD_MAX;
                    carry_out  = 1'b1;
                end else begin
                    digit_next = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/counter_bcd_updown_snapshot.sv
// N-digit BCD up/down counter with clear, clamped parallel load, wrap or
// saturate at the limits, sticky overflow and a snapshot register for display.
module counter_bcd_updown_snapshot
    import bcd_pkg::*;
#(
    parameter int DIGITS_NUM = 6,
    parameter bit SATURATE   = 1'b0
)
(
    input  logic                              clk_in,
    input  logic                              reset_in,
    input  logic                              enable_in,
    input  logic                              up_in,
    input  logic                              clear_in,
    input  logic                              load_in,
    input  logic [4*DIGITS_NUM-1:0]           load_value_in,
    input  logic                              snapshot_in,
    output logic [4*DIGITS_NUM-1:0]           digits_out,
    output logic [4*DIGITS_NUM-1:0]           snapshot_out,
    output logic                              snapshot_valid_out,
    output logic                              wrap_out,
    output logic                              overflow_out,
    output logic                              load_error_out,
    output logic [$clog2(DIGITS_NUM+1)-1:0]   lead_zeros_out
);

    localparam int W    = 4 * DIGITS_NUM;
    localparam int LZ_W = $clog2(DIGITS_NUM + 1);

    logic [W-1:0]          digits_reg;
    logic [W-1:0]          digits_next;
    logic [W-1:0]          snapshot_reg;
    logic [W-1:0]          load_sat;
    logic [W-1:0]          count_step;
    logic [DIGITS_NUM-1:0] load_bad;
    logic [DIGITS_NUM:0]   carry;
    logic                  limit_hit;
    logic                  snapshot_valid_reg;
    logic                  wrap_reg;
    logic                  wrap_next;
    logic                  overflow_reg;
    logic                  overflow_next;
    logic                  load_error_reg;
    logic                  load_error_next;
    logic [4*MAX_DIGITS-1:0] snapshot_wide;
    count_action_e         action;

    // The chain always steps; enable is applied by the action decode below.
    assign carry[0]  = 1'b1;
    assign limit_hit = carry[DIGITS_NUM];

    generate
        for (genvar gi = 0; gi < DIGITS_NUM; gi++) begin : g_digit
            bcd_digit_updown u_digit (
                .digit      (digits_reg[4*gi +: 4]),
                .up         (up_in),
                .carry_in   (carry[gi]),
                .digit_next (count_step[4*gi +: 4]),
                .carry_out  (carry[gi+1])
            );

            assign load_sat[4*gi +: 4] = bcd_sat(load_value_in[4*gi +: 4]);
            assign load_bad[gi]        = (load_value_in[4*gi +: 4] > BCD_MAX);
        end
    endgenerate

    always_comb begin
        action = ACT_HOLD;
        if (clear_in) begin
            action = ACT_CLEAR;
        end else if (load_in) begin
            action = ACT_LOAD;
        end else if (enable_in) begin
            action = ACT_COUNT;
        end
    end

    always_comb begin
        digits_next     = digits_reg;
        overflow_next   = overflow_reg;
        wrap_next       = 1'b0;
        load_error_next = 1'b0;
        case (action)
            ACT_CLEAR: begin
                digits_next   = '0;
                overflow_next = 1'b0;
            end
            ACT_LOAD: begin
                digits_next     = load_sat;
                load_error_next = |load_bad;
            end
            ACT_COUNT: begin
                digits_next = count_step;
                if (limit_hit) begin
                    wrap_next     = 1'b1;
                    overflow_next = 1'b1;
                    if (SATURATE) begin
                        digits_next = digits_reg;
                    end
                end
            end
            default: begin
                digits_next = digits_reg;
            end
        endcase
    end

    // Snapshot samples the pre-edge count so a gate-end clear loses nothing.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            digits_reg         <= '0;
            snapshot_reg       <= '0;
            snapshot_valid_reg <= 1'b0;
            wrap_reg           <= 1'b0;
            overflow_reg       <= 1'b0;
            load_error_reg     <= 1'b0;
        end else begin
            digits_reg     <= digits_next;
            wrap_reg       <= wrap_next;
            overflow_reg   <= overflow_next;
            load_error_reg <= load_error_next;
            if (snapshot_in) begin
                snapshot_reg       <= digits_reg;
                snapshot_valid_reg <= 1'b1;
            end
        end
    end

    assign snapshot_wide = (4*MAX_DIGITS)'(snapshot_reg);

    assign digits_out         = digits_reg;
    assign snapshot_out       = snapshot_reg;
    assign snapshot_valid_out = snapshot_valid_reg;
    assign wrap_out           = wrap_reg;
    assign overflow_out       = overflow_reg;
    assign load_error_out     = load_error_reg;
    assign lead_zeros_out     = LZ_W'(leading_zeros(snapshot_wide, DIGITS_NUM));

endmodule

// File: tb/tb_counter_bcd_updown_snapshot.sv
// Directed bench: a wrapping and a saturating 3-digit counter share the same
// stimulus; each task checks its scenario against hand-computed values.
module tb_counter_bcd_updown_snapshot;

    logic        clk_in;
    logic        reset_in;
    logic        enable_in;
    logic        up_in;
    logic        clear_in;
    logic        load_in;
    logic [11:0] load_value_in;
    logic        snapshot_in;

    logic [11:0] w_digits, w_snap;
    logic        w_valid, w_wrap, w_ovf, w_lerr;
    logic [1:0]  w_lz;
    logic [11:0] s_digits, s_snap;
    logic        s_valid, s_wrap, s_ovf, s_lerr;
    logic [1:0]  s_lz;

    int total = 0;
    int bad   = 0;

    counter_bcd_updown_snapshot #(.DIGITS_NUM(3), .SATURATE(1'b0)) dut_wrap (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .up_in(up_in),
        .clear_in(clear_in), .load_in(load_in), .load_value_in(load_value_in),
        .snapshot_in(snapshot_in), .digits_out(w_digits), .snapshot_out(w_snap),
        .snapshot_valid_out(w_valid), .wrap_out(w_wrap), .overflow_out(w_ovf),
        .load_error_out(w_lerr), .lead_zeros_out(w_lz)
    );

    counter_bcd_updown_snapshot #(.DIGITS_NUM(3), .SATURATE(1'b1)) dut_sat (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .up_in(up_in),
        .clear_in(clear_in), .load_in(load_in), .load_value_in(load_value_in),
        .snapshot_in(snapshot_in), .digits_out(s_digits), .snapshot_out(s_snap),
        .snapshot_valid_out(s_valid), .wrap_out(s_wrap), .overflow_out(s_ovf),
        .load_error_out(s_lerr), .lead_zeros_out(s_lz)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic idle();
        enable_in     = 1'b0;
        up_in         = 1'b1;
        clear_in      = 1'b0;
        load_in       = 1'b0;
        load_value_in = 12'h000;
        snapshot_in   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input logic [11:0] value);
        idle();
        load_in       = 1'b1;
        load_value_in = value;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_in = 1'b1;
        #2;
        reset_in = 1'b0;
        #1;
        total++;
        if ({w_digits, w_snap, w_valid, w_wrap, w_ovf, w_lerr} !== 28'h0) begin
            bad++;
            $display("FAIL reset_wrap got digits=%h snap=%h v=%b w=%b o=%b e=%b want all 0", w_digits, w_snap, w_valid, w_wrap, w_ovf, w_lerr);
        end
        total++;
        if ({s_digits, s_snap, s_valid, s_wrap, s_ovf, s_lerr} !== 28'h0) begin
            bad++;
            $display("FAIL reset_sat got digits=%h snap=%h v=%b w=%b o=%b e=%b want all 0", s_digits, s_snap, s_valid, s_wrap, s_ovf, s_lerr);
        end
        total++;
        if (w_lz !== 2'd2) begin
            bad++;
            $display("FAIL reset_lead_zeros got=%0d want=2", w_lz);
        end
        #20;
        reset_in = 1'b1;
        $display("reset: released at %0t", $time);
    endtask

    task automatic test_wrap_up();
        logic [11:0] exp_w [3];
        logic [11:0] exp_s [3];
        logic        exp_wr [3];
        exp_w  = '{12'h998, 12'h999, 12'h000};
        exp_s  = '{12'h998, 12'h999, 12'h999};
        exp_wr = '{1'b0, 1'b0, 1'b1};
        do_load(12'h997);
        total++;
        if (w_digits !== 12'h997) begin
            bad++;
            $display("FAIL load_997 got=%h want=997", w_digits);
        end
        enable_in = 1'b1;
        up_in     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("wrap_up step %0d: wrap=%h sat=%h wrap_out=%b/%b", i, w_digits, s_digits, w_wrap, s_wrap);
            total++;
            if (w_digits !== exp_w[i] || w_wrap !== exp_wr[i]) begin
                bad++;
                $display("FAIL wrap_up_%0d got=%h/%b want=%h/%b", i, w_digits, w_wrap, exp_w[i], exp_wr[i]);
            end
            total++;
            if (s_digits !== exp_s[i] || s_wrap !== exp_wr[i]) begin
                bad++;
                $display("FAIL sat_up_%0d got=%h/%b want=%h/%b", i, s_digits, s_wrap, exp_s[i], exp_wr[i]);
            end
        end
        total++;
        if (w_ovf !== 1'b1 || s_ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set got=%b/%b want=1/1", w_ovf, s_ovf);
        end
        idle();
        tick();
        total++;
        if (w_wrap !== 1'b0 || w_ovf !== 1'b1 || w_digits !== 12'h000) begin
            bad++;
            $display("FAIL wrap_pulse_end got wrap=%b ovf=%b digits=%h want 0/1/000", w_wrap, w_ovf, w_digits);
        end
    endtask

    task automatic test_load();
        do_load(12'h1A5);
        $display("load 1A5: digits=%h err=%b ovf=%b", w_digits, w_lerr, w_ovf);
        total++;
        if (w_digits !== 12'h195 || w_lerr !== 1'b1) begin
            bad++;
            $display("FAIL load_clamp got=%h err=%b want=195 err=1", w_digits, w_lerr);
        end
        total++;
        if (w_ovf !== 1'b1) begin
            bad++;
            $display("FAIL load_keeps_overflow got=%b want=1", w_ovf);
        end
        tick();
        total++;
        if (w_lerr !== 1'b0 || w_digits !== 12'h195) begin
            bad++;
            $display("FAIL load_err_pulse got err=%b digits=%h want 0/195", w_lerr, w_digits);
        end
        clear_in      = 1'b1;
        load_in       = 1'b1;
        load_value_in = 12'h1A5;
        enable_in     = 1'b1;
        tick();
        idle();
        $display("clear+load: digits=%h err=%b ovf=%b", w_digits, w_lerr, w_ovf);
        total++;
        if (w_digits !== 12'h000 || w_lerr !== 1'b0 || w_ovf !== 1'b0 || s_ovf !== 1'b0) begin
            bad++;
            $display("FAIL clear_over_load got=%h err=%b ovf=%b/%b want=000 0 0/0", w_digits, w_lerr, w_ovf, s_ovf);
        end
    endtask

    task automatic test_sat_down();
        logic [11:0] exp_s [4];
        logic [11:0] exp_w [4];
        logic        exp_sw [4];
        logic        exp_ww [4];
        exp_s  = '{12'h001, 12'h000, 12'h000, 12'h000};
        exp_sw = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_w  = '{12'h001, 12'h000, 12'h999, 12'h998};
        exp_ww = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_load(12'h002);
        enable_in = 1'b1;
        up_in     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("sat_down step %0d: sat=%h wrap=%h wrap_out=%b/%b", i, s_digits, w_digits, s_wrap, w_wrap);
            total++;
            if (s_digits !== exp_s[i] || s_wrap !== exp_sw[i]) begin
                bad++;
                $display("FAIL sat_down_%0d got=%h/%b want=%h/%b", i, s_digits, s_wrap, exp_s[i], exp_sw[i]);
            end
            total++;
            if (w_digits !== exp_w[i] || w_wrap !== exp_ww[i]) begin
                bad++;
                $display("FAIL wrap_down_%0d got=%h/%b want=%h/%b", i, w_digits, w_wrap, exp_w[i], exp_ww[i]);
            end
        end
        total++;
        if (s_ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_overflow got=%b want=1", s_ovf);
        end
        clear_in = 1'b1;
        tick();
        idle();
        total++;
        if (s_digits !== 12'h000 || s_ovf !== 1'b0 || w_ovf !== 1'b0) begin
            bad++;
            $display("FAIL sat_clear got=%h ovf=%b/%b want=000 0/0", s_digits, s_ovf, w_ovf);
        end
    endtask

    task automatic test_snapshot();
        total++;
        if (w_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_before_snapshot got=%b want=0", w_valid);
        end
        do_load(12'h123);
        clear_in    = 1'b1;
        snapshot_in = 1'b1;
        enable_in   = 1'b1;
        up_in       = 1'b1;
        tick();
        idle();
        $display("gate end: snap=%h digits=%h valid=%b lz=%0d", w_snap, w_digits, w_valid, w_lz);
        total++;
        if (w_snap !== 12'h123 || w_digits !== 12'h000 || w_valid !== 1'b1) begin
            bad++;
            $display("FAIL gate_end got snap=%h digits=%h valid=%b want 123/000/1", w_snap, w_digits, w_valid);
        end
        total++;
        if (w_lz !== 2'd0) begin
            bad++;
            $display("FAIL lz_123 got=%0d want=0", w_lz);
        end
    endtask

    task automatic test_lead_zeros();
        logic [11:0] vals [4];
        logic [1:0]  exp_lz [4];
        vals   = '{12'h005, 12'h000, 12'h100, 12'h050};
        exp_lz = '{2'd2, 2'd2, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            do_load(vals[i]);
            snapshot_in = 1'b1;
            tick();
            idle();
            $display("lead_zeros: snap=%h lz=%0d", w_snap, w_lz);
            total++;
            if (w_snap !== vals[i] || w_lz !== exp_lz[i]) begin
                bad++;
                $display("FAIL lead_zeros_%0d got snap=%h lz=%0d want %h/%0d", i, w_snap, w_lz, vals[i], exp_lz[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_d [2];
        logic [11:0] exp_p [2];
        exp_d = '{12'h011, 12'h012};
        exp_p = '{12'h010, 12'h011};
        do_load(12'h010);
        enable_in   = 1'b1;
        up_in       = 1'b1;
        snapshot_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            $display("back_to_back %0d: digits=%h snap=%h", i, w_digits, w_snap);
            total++;
            if (w_digits !== exp_d[i] || w_snap !== exp_p[i]) begin
                bad++;
                $display("FAIL back_to_back_%0d got %h/%h want %h/%h", i, w_digits, w_snap, exp_d[i], exp_p[i]);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_load(12'h050);
        enable_in = 1'b1;
        up_in     = 1'b1;
        tick();
        tick();
        total++;
        if (w_digits !== 12'h052) begin
            bad++;
            $display("FAIL pre_reset_count got=%h want=052", w_digits);
        end
        #2;
        reset_in = 1'b0;
        #1;
        $display("async reset: digits=%h/%h snap=%h valid=%b", w_digits, s_digits, w_snap, w_valid);
        total++;
        if ({w_digits, w_snap, w_valid, w_wrap, w_ovf, w_lerr} !== 28'h0 || s_digits !== 12'h000 || s_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got digits=%h snap=%h valid=%b sat=%h want all 0", w_digits, w_snap, w_valid, s_digits);
        end
        tick();
        total++;
        if (w_digits !== 12'h000) begin
            bad++;
            $display("FAIL reset_holds got=%h want=000", w_digits);
        end
        #2;
        reset_in = 1'b1;
        tick();
        $display("resume: digits=%h/%h", w_digits, s_digits);
        total++;
        if (w_digits !== 12'h001 || s_digits !== 12'h001) begin
            bad++;
            $display("FAIL resume_count got=%h/%h want=001/001", w_digits, s_digits);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_load();
        test_sat_down();
        test_snapshot();
        test_lead_zeros();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
